// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lot blocks: gate state encoding and default sizing.
`default_nettype none

package parking_pkg;

  localparam int DEFAULT_CNT_W    = 4;
  localparam int DEFAULT_CAPACITY = 15;

  typedef enum logic [1:0] {
    GATE_IDLE = 2'd0,
    GATE_OPEN = 2'd1,
    GATE_HOLD = 2'd2
  } gate_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_fsm.sv
// Per-barrier sequencer: IDLE -> OPEN (await pass or timeout) -> HOLD -> IDLE.
`default_nettype none

module gate_fsm
  import parking_pkg::*;
#(
  parameter int OPEN_TIMEOUT = 200,
  parameter int CLOSE_HOLD   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_pass,
  input  logic i_allow,
  output logic o_gate_open,
  output logic o_event
);

  localparam int TMAX = max2(OPEN_TIMEOUT, CLOSE_HOLD);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(CLOSE_HOLD - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TMAX);

  gate_state_t   r_state;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;

  assign w_timer_next = (r_timer == TIMER_MAX) ? r_timer : r_timer + 1'b1;

  // Only a pass seen while waiting in OPEN counts; late or stray pulses are dropped.
  assign o_event = (r_state == GATE_OPEN) & i_pass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= GATE_IDLE;
      r_timer     <= '0;
      o_gate_open <= 1'b0;
    end else begin
      case (r_state)
        GATE_IDLE: begin
          if (i_req && i_allow) begin
            r_state     <= GATE_OPEN;
            r_timer     <= '0;
            o_gate_open <= 1'b1;
          end
        end
        GATE_OPEN: begin
          if (i_pass) begin
            r_state <= GATE_HOLD;
            r_timer <= '0;
          end else if (r_timer == OPEN_LAST) begin
            r_state     <= GATE_IDLE;
            r_timer     <= '0;
            o_gate_open <= 1'b0;
          end else begin
            r_timer <= w_timer_next;
          end
        end
        GATE_HOLD: begin
          if (r_timer == HOLD_LAST) begin
            r_state     <= GATE_IDLE;
            r_timer     <= '0;
            o_gate_open <= 1'b0;
          end else begin
            r_timer <= w_timer_next;
          end
        end
        default: begin
          r_state     <= GATE_IDLE;
          r_timer     <= '0;
          o_gate_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/parking_gate_controller.sv
// Entry/exit barrier control with a serialising inc/dec arbiter and lot-full gating.
`default_nettype none

module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int CNT_W        = DEFAULT_CNT_W,
  parameter int CAPACITY     = DEFAULT_CAPACITY,
  parameter int OPEN_TIMEOUT = 200,
  parameter int CLOSE_HOLD   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_entry_req,
  input  logic             i_entry_pass,
  input  logic             i_exit_req,
  input  logic             i_exit_pass,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_inc,
  output logic             o_dec,
  output logic             o_entry_gate_open,
  output logic             o_exit_gate_open,
  output logic             o_full,
  output logic             o_entry_denied
);

  localparam logic [CNT_W:0] CAP_W = (CNT_W + 1)'(CAPACITY);

  logic             w_entry_event;
  logic             w_exit_event;
  logic [CNT_W:0]   w_occupancy;
  logic             r_pending_inc;
  logic             r_pending_dec;

  gate_fsm #(
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .CLOSE_HOLD   (CLOSE_HOLD)
  ) u_entry_gate (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_entry_req),
    .i_pass      (i_entry_pass),
    .i_allow     (~o_full),
    .o_gate_open (o_entry_gate_open),
    .o_event     (w_entry_event)
  );

  gate_fsm #(
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .CLOSE_HOLD   (CLOSE_HOLD)
  ) u_exit_gate (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_exit_req),
    .i_pass      (i_exit_pass),
    .i_allow     (1'b1),
    .o_gate_open (o_exit_gate_open),
    .o_event     (w_exit_event)
  );

  // A pending increment already counts toward occupancy so a second car cannot slip in.
  assign w_occupancy = {1'b0, i_count} + {{CNT_W{1'b0}}, r_pending_inc};
  assign o_full      = (w_occupancy >= CAP_W);

  // Exit wins arbitration; an entry strobe waits one cycle if both are pending.
  assign o_dec = r_pending_dec;
  assign o_inc = r_pending_inc & ~r_pending_dec;

  // The gate's open flag is low exactly when its sequencer sits in IDLE.
  assign o_entry_denied = i_entry_req & o_full & ~o_entry_gate_open;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending_inc <= 1'b0;
      r_pending_dec <= 1'b0;
    end else begin
      r_pending_dec <= w_exit_event;
      r_pending_inc <= w_entry_event | (r_pending_inc & ~o_inc);
    end
  end

endmodule

`default_nettype wire
